sass_r: RTL and testbench

SASS serial receiver. Sits directly downstream of the SASS transmitter (sass_t) in the SASS transceiver and consumes its single-wire output line. It recovers one frame_l-bit word per frame by oversampling the line at the same bit period t. It presents the word on a parallel bus with a one-cycle valid strobe, and flags framing errors.

---
 rtl/sass_r.sv | 117 +++++++++++
 tb/tb_sass_r.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sass_r.sv
// SASS serial receiver: 2-flop synchronised line, start-edge detect, centre sampling,
// LSB-first shift-in, one-cycle valid/err strobes on stop-bit check.
module sass_r #(
    parameter int frame_l = 8,
    parameter int t       = 100
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s,
    output logic [frame_l-1:0] data,
    output logic               valid,
    output logic               err,
    output logic               busy
);

    localparam int cw = $clog2(t);
    localparam int bw = $clog2(frame_l + 1);

    localparam logic [cw-1:0] half_m1  = cw'(t / 2 - 1);
    localparam logic [cw-1:0] full_m1  = cw'(t - 1);
    localparam logic [bw-1:0] last_bit = bw'(frame_l - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic               s_meta;
    logic               s_sync;
    logic               s_prev;
    logic [cw-1:0]      cnt;
    logic [bw-1:0]      bit_idx;
    logic [frame_l-1:0] sh;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s_meta  <= 1'b1;
            s_sync  <= 1'b1;
            s_prev  <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            sh      <= '0;
            data    <= '0;
            valid   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            s_meta <= s;
            s_sync <= s_meta;
            s_prev <= s_sync;
            valid  <= 1'b0;
            err    <= 1'b0;

            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    cnt  <= '0;
                    // Only a high-to-low transition starts a frame; a line held low never does.
                    if (s_prev && !s_sync) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == half_m1) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        if (!s_sync) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == full_m1) begin
                        cnt     <= '0;
                        sh      <= {s_sync, sh[frame_l-1:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == last_bit) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
                    if (cnt == full_m1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (s_sync) begin
                            data  <= sh;
                            valid <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sass_r.sv
// Directed bench for sass_r: hand-driven SASS frames, expected strobes queued on send
// and checked by a monitor whenever valid or err fires.
module tb_sass_r;

    localparam int FL = 8;
    localparam int T  = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          s   = 1'b1;
    logic [FL-1:0] data;
    logic          valid;
    logic          err;
    logic          busy;

    always #5 clk = ~clk;

    sass_r #(.frame_l(FL), .t(T)) dut (
        .clk  (clk),
        .rst  (rst),
        .s    (s),
        .data (data),
        .valid(valid),
        .err  (err),
        .busy (busy)
    );

    typedef struct packed {
        logic          is_err;
        logic [FL-1:0] word;
    } exp_t;

    exp_t q[$];
    int   ev_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (valid || err) begin
            ev_cyc.push_back(cyc);
            total++;
            assert (!(valid && err)) else begin
                bad++;
                $error("FAIL both_strobes valid=%b err=%b required=not_both", valid, err);
            end
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL unexpected_strobe valid=%b err=%b data=%h required=no_strobe", valid, err, data);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                total++;
                assert (err === e.is_err) else begin
                    bad++;
                    $error("FAIL strobe_kind err=%b required=%b", err, e.is_err);
                end
                total++;
                assert (data === e.word) else begin
                    bad++;
                    $error("FAIL strobe_data got=%h required=%h", data, e.word);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%0h required=%0h", tag, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic v, input int n);
        s = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [FL-1:0] d, input logic stop);
        start_cyc = cyc;
        drive(1'b0, T);
        for (int i = 0; i < FL; i++) drive(d[i], T);
        drive(stop, T);
        s = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3 * T && q.size() != 0; i++) @(negedge clk);
        chk(tag, q.size(), 0);
    endtask

    function automatic int last_ev(input int back);
        if (ev_cyc.size() > back) return ev_cyc[ev_cyc.size() - 1 - back];
        return 0;
    endfunction

    initial begin
        int lat;
        int n_ev;
        logic [FL-1:0] d;

        // Reset state
        s   = 1'b1;
        rst = 1'b0;
        idle(3);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b1;
        idle(20);

        // Two clean frames with a long idle gap
        q.push_back(exp_t'{1'b0, 8'h87});
        send_frame(8'd135, 1'b1);
        drain("f1_drain");
        lat = last_ev(0) - start_cyc;
        chk("f1_latency_in_952_954", (lat >= 952 && lat <= 954), 1);
        idle(100);
        chk("f1_busy_idle", busy, 0);
        chk("f1_data_hold", data, 8'h87);
        idle(2000);
        q.push_back(exp_t'{1'b0, 8'h5F});
        send_frame(8'd95, 1'b1);
        drain("f2_drain");
        chk("f2_data", data, 8'h5F);
        idle(100);
        chk("f2_busy_idle", busy, 0);

        // Short low glitch from idle: busy for ~half a bit, then nothing
        drive(1'b0, 20);
        s = 1'b1;
        chk("glitch_busy_high", busy, 1);
        idle(40);
        chk("glitch_busy_low", busy, 0);
        idle(100);
        chk("glitch_data_kept", data, 8'h5F);

        // Framing error, then a good frame
        q.push_back(exp_t'{1'b1, 8'h5F});
        send_frame(8'hA5, 1'b0);
        drain("ferr_drain");
        lat = last_ev(0) - start_cyc;
        chk("ferr_latency_in_952_954", (lat >= 952 && lat <= 954), 1);
        chk("ferr_data_kept", data, 8'h5F);
        idle(200);
        q.push_back(exp_t'{1'b0, 8'h3C});
        send_frame(8'h3C, 1'b1);
        drain("good_after_err_drain");
        chk("good_after_err_data", data, 8'h3C);

        // Back-to-back frames, no idle gap
        idle(200);
        q.push_back(exp_t'{1'b0, 8'h00});
        q.push_back(exp_t'{1'b0, 8'hFF});
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        drain("b2b_drain");
        chk("b2b_spacing", last_ev(0) - last_ev(1), 10 * T);
        chk("b2b_data", data, 8'hFF);

        // Reset during data bit 4
        idle(200);
        n_ev = ev_cyc.size();
        d = 8'h33;
        drive(1'b0, T);
        for (int i = 0; i < 4; i++) drive(d[i], T);
        drive(d[4], T / 2);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        s   = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_data", data, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_err", err, 0);
        rst = 1'b1;
        idle(3 * T);
        chk("midrst_no_strobe", ev_cyc.size(), n_ev);
        q.push_back(exp_t'{1'b0, 8'h5A});
        send_frame(8'h5A, 1'b1);
        drain("after_rst_drain");
        chk("after_rst_data", data, 8'h5A);

        // Frame whose stop bit never comes: line stays low
        idle(200);
        n_ev = ev_cyc.size();
        q.push_back(exp_t'{1'b1, 8'h5A});
        d = 8'hA5;
        drive(1'b0, T);
        for (int i = 0; i < FL; i++) drive(d[i], T);
        drive(1'b0, 5000);
        chk("stuck_busy", busy, 0);
        chk("stuck_one_err", ev_cyc.size(), n_ev + 1);
        chk("stuck_queue", q.size(), 0);
        s = 1'b1;
        idle(300);
        chk("stuck_release_idle", ev_cyc.size(), n_ev + 1);
        q.push_back(exp_t'{1'b0, 8'hC3});
        send_frame(8'hC3, 1'b1);
        drain("recover_drain");
        chk("recover_data", data, 8'hC3);

        idle(50);
        chk("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
